// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter for the async FIFO (rclk domain).
// Two-entry registered skid buffer with flush/drain and delivery/drop counters.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  pop_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    logic [1:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_e0;
    logic [DATA_WIDTH-1:0] r_e1;
    logic [CNT_WIDTH-1:0]  r_pop;
    logic [CNT_WIDTH-1:0]  r_drop;

    logic                  w_full;
    logic                  w_rinc;
    logic                  w_mvalid;
    logic                  w_deq;
    logic [1:0]            w_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_e0_nxt;
    logic [DATA_WIDTH-1:0] w_e1_nxt;
    logic [CNT_WIDTH-1:0]  w_pop_nxt;
    logic [CNT_WIDTH-1:0]  w_drop_nxt;

    // Pop decision depends only on FIFO state and buffer fill, never on m_ready.
    assign w_full   = (r_cnt == 2'd2);
    assign w_rinc   = ~rempty & (flush | ~w_full);
    assign w_mvalid = ~flush & (r_cnt != 2'd0);
    assign w_deq    = w_mvalid & m_ready;

    // Next-state for buffer entries, fill level and counters.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_e0_nxt   = r_e0;
        w_e1_nxt   = r_e1;
        w_pop_nxt  = r_pop;
        w_drop_nxt = r_drop;
        if (flush) begin
            w_cnt_nxt  = 2'd0;
            w_drop_nxt = r_drop + CNT_WIDTH'(r_cnt) + CNT_WIDTH'(w_rinc);
        end else begin
            unique case ({w_rinc, w_deq})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        w_e0_nxt = rdata;
                    end else begin
                        w_e1_nxt = rdata;
                    end
                    w_cnt_nxt = r_cnt + 2'd1;
                end
                2'b01: begin
                    // Only a valid second entry may move into the head.
                    if (r_cnt == 2'd2) begin
                        w_e0_nxt = r_e1;
                    end
                    w_cnt_nxt = r_cnt - 2'd1;
                end
                2'b11: begin
                    w_e0_nxt = rdata;
                end
                default: begin
                end
            endcase
            if (w_deq) begin
                w_pop_nxt = r_pop + CNT_WIDTH'(1);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_cnt  <= 2'd0;
            r_e0   <= '0;
            r_e1   <= '0;
            r_pop  <= '0;
            r_drop <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_e0   <= w_e0_nxt;
            r_e1   <= w_e1_nxt;
            r_pop  <= w_pop_nxt;
            r_drop <= w_drop_nxt;
        end
    end

    assign rinc       = w_rinc;
    assign m_valid    = w_mvalid;
    assign m_data     = r_e0;
    assign pop_count  = r_pop;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a queue-based FIFO model
// and an output scoreboard.
module tb_fifo_rd_stream;

    localparam int DW = 16;
    localparam int CW = 4;
    localparam int MASK = (1 << CW) - 1;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] pop_count;
    logic [CW-1:0] drop_count;

    fifo_rd_stream #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .pop_count (pop_count),
        .drop_count(drop_count)
    );

    always #5 rclk = ~rclk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            exp_pop = 0;
    int            exp_drop = 0;
    int            fifo_pops = 0;
    int            delivered = 0;
    logic          t_pop;
    logic          hold = 1'b0;
    logic [DW-1:0] hold_data;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        rempty = (fifo_q.size() == 0);
        rdata  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [DW-1:0] w, input bit scored);
        fifo_q.push_back(w);
        if (scored) exp_q.push_back(w);
        upd();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge rclk);
        #2;
    endtask

    task automatic wait_drain(input string tag, input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) step(1);
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // FIFO model: remove the head one tick after an edge that saw rinc.
    always @(posedge rclk) begin
        t_pop = rinc & rrst_n;
        #1;
        if (t_pop && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            fifo_pops++;
            upd();
        end
    end

    // Output monitor: ordering, stability under backpressure, flush gating.
    always @(negedge rclk) begin
        if (rrst_n) begin
            if (rempty) check("rinc_when_empty", 64'(rinc), 64'd0);
            if (flush) begin
                check("flush_mvalid", 64'(m_valid), 64'd0);
            end else begin
                if (hold) begin
                    check("hold_valid", 64'(m_valid), 64'd1);
                    check("hold_data", 64'(m_data), 64'(hold_data));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL extra_word obs=%0h exp=none", m_data);
                    end else begin
                        check("order", 64'(m_data), 64'(exp_q.pop_front()));
                        delivered++;
                        exp_pop++;
                    end
                end
            end
        end
        hold      = rrst_n && !flush && m_valid && !m_ready;
        hold_data = m_data;
    end

    initial begin
        int p0;
        int d0;
        rrst_n  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        upd();
        step(2);
        check("rst_mvalid", 64'(m_valid), 64'd0);
        check("rst_mdata", 64'(m_data), 64'd0);
        check("rst_pop", 64'(pop_count), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_rinc", 64'(rinc), 64'd0);
        rrst_n = 1'b1;
        step(1);

        // Streaming: 16 words, no bubbles once data is present.
        for (int i = 1; i <= 16; i++) push(DW'(i), 1'b1);
        m_ready = 1'b1;
        d0 = delivered;
        step(16);
        check("stream_one_left", 64'(exp_q.size()), 64'd1);
        step(1);
        check("stream_drained", 64'(exp_q.size()), 64'd0);
        check("stream_count", 64'(delivered - d0), 64'd16);
        check("stream_pop", 64'(pop_count), 64'(exp_pop & MASK));

        // Backpressure: only two words are pulled while stalled.
        m_ready = 1'b0;
        p0 = fifo_pops;
        for (int i = 0; i < 4; i++) push(DW'(16'h40 + i), 1'b1);
        step(10);
        check("bp_pops", 64'(fifo_pops - p0), 64'd2);
        check("bp_rinc", 64'(rinc), 64'd0);
        check("bp_mdata", 64'(m_data), 64'h40);
        check("bp_mvalid", 64'(m_valid), 64'd1);
        m_ready = 1'b1;
        wait_drain("bp_drain", 20);
        check("bp_pop", 64'(pop_count), 64'(exp_pop & MASK));

        // Single-cycle bubbles on m_ready.
        d0 = delivered;
        for (int i = 0; i < 20; i++) push(DW'(16'h100 + i), 1'b1);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            m_ready = ~m_ready;
            step(1);
        end
        check("bubble_drain", 64'(exp_q.size()), 64'd0);
        check("bubble_count", 64'(delivered - d0), 64'd20);

        // Flush: two buffered plus five in the FIFO are all dropped.
        m_ready = 1'b0;
        step(2);
        for (int i = 0; i < 7; i++) push(DW'(16'h70 + i), 1'b1);
        step(3);
        check("fl_fifo_left", 64'(fifo_q.size()), 64'd5);
        p0 = exp_pop;
        exp_q.delete();
        flush = 1'b1;
        step(8);
        flush = 1'b0;
        exp_drop = exp_drop + 7;
        check("fl_rempty", 64'(rempty), 64'd1);
        check("fl_drop", 64'(drop_count), 64'(exp_drop & MASK));
        check("fl_pop", 64'(pop_count), 64'(p0 & MASK));

        // Flush coinciding with a pop: the word is dropped, never delivered.
        m_ready = 1'b1;
        push(16'hBEEF, 1'b0);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        exp_drop = exp_drop + 1;
        step(2);
        check("fle_drop", 64'(drop_count), 64'(exp_drop & MASK));
        check("fle_mvalid", 64'(m_valid), 64'd0);
        check("fle_rempty", 64'(rempty), 64'd1);

        // Asynchronous reset while the buffer is full.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(DW'(16'hA1 + i), 1'b1);
        step(3);
        check("ar_pre_valid", 64'(m_valid), 64'd1);
        check("ar_pre_fifo", 64'(fifo_q.size()), 64'd1);
        rrst_n = 1'b0;
        #1;
        check("ar_mvalid", 64'(m_valid), 64'd0);
        check("ar_mdata", 64'(m_data), 64'd0);
        check("ar_pop", 64'(pop_count), 64'd0);
        check("ar_drop", 64'(drop_count), 64'd0);
        fifo_q.delete();
        exp_q.delete();
        upd();
        exp_pop  = 0;
        exp_drop = 0;
        step(2);
        rrst_n = 1'b1;
        step(1);

        // Counter wrap: 17 deliveries with a 4-bit counter.
        for (int i = 0; i < 17; i++) push(DW'(16'h200 + i), 1'b1);
        m_ready = 1'b1;
        wait_drain("wrap_drain", 40);
        check("wrap_pop", 64'(pop_count), 64'd1);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
